// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook timer.
package mw_pkg;

    // One-hot FSM encoding: each output is one flop of the state register.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ARM  = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    typedef logic [3:0]  bcd_t;
    typedef logic [15:0] mmss_t;

    localparam mmss_t TIME_ZERO = 16'h0000;
    localparam bcd_t  BCD_MAX   = 4'd9;
    localparam bcd_t  BCD_ZERO  = 4'd0;
    localparam bcd_t  BCD_ONE   = 4'd1;

    // Single BCD digit decrement, wrapping 0 -> 9 (the caller handles the borrow).
    function automatic bcd_t bcd_dec(input bcd_t d);
        bcd_t r;
        if (d == BCD_ZERO) begin
            r = BCD_MAX;
        end else begin
            r = d - BCD_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/mw_time_dec.sv
// Combinational MM:SS BCD decrement. Seconds above 59 count down as entered;
// an all-zero seconds field borrows one minute and reloads 59.
// o_zero flags that the decremented result is 00:00.
import mw_pkg::*;

module mw_time_dec (
    input  mmss_t i_time,
    output mmss_t o_time,
    output logic  o_zero
);

    // Digit-wise decrement with borrow from the next digit up.
    always_comb begin
        o_time = i_time;
        if (i_time[7:0] == 8'h00) begin
            if (i_time[11:8] == BCD_ZERO) begin
                o_time[15:12] = i_time[15:12] - BCD_ONE;
            end else begin
                o_time[15:12] = i_time[15:12];
            end
            o_time[11:8] = bcd_dec(i_time[11:8]);
            o_time[7:0]  = 8'h59;
        end else begin
            o_time[15:8] = i_time[15:8];
            if (i_time[3:0] == BCD_ZERO) begin
                o_time[7:4] = i_time[7:4] - BCD_ONE;
            end else begin
                o_time[7:4] = i_time[7:4];
            end
            o_time[3:0] = bcd_dec(i_time[3:0]);
        end
    end

    assign o_zero = (o_time == TIME_ZERO);

endmodule

// File: rtl/cook_timer.sv
// Cook timer: keypad MM:SS entry, start handshake, heat-gated countdown and
// finish pulse towards the oven controller. All outputs come straight from flops.
import mw_pkg::*;

module cook_timer #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic        start_btn,
    input  logic        heat,
    output logic        start,
    output logic        finish,
    output logic        running,
    output logic [15:0] disp
);

    localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    mmss_t         r_time;
    mmss_t         w_time_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    mmss_t         w_dec_time;
    logic          w_dec_zero;

    mw_time_dec u_time_dec (
        .i_time (r_time),
        .o_time (w_dec_time),
        .o_zero (w_dec_zero)
    );

    // State, time and prescaler registers; reset forces every output low at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_time  <= TIME_ZERO;
            r_presc <= PRESC_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next-state, keypad shift and countdown logic.
    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_presc_nxt = r_presc;
        case (r_state)
            IDLE: begin
                // Key activity wins over start_btn in the same cycle.
                if (key_clear) begin
                    w_time_nxt = TIME_ZERO;
                end else if (key_valid) begin
                    if (key_digit <= BCD_MAX) begin
                        w_time_nxt = {r_time[11:0], key_digit};
                    end else begin
                        w_time_nxt = r_time;
                    end
                end else if (start_btn && (r_time != TIME_ZERO)) begin
                    w_state_nxt = ARM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ARM: begin
                w_presc_nxt = PRESC_ZERO;
                w_state_nxt = RUN;
            end
            RUN: begin
                // Cancel beats a coincident tick; finish is still issued.
                if (key_clear) begin
                    w_time_nxt  = TIME_ZERO;
                    w_state_nxt = DONE;
                end else if (heat) begin
                    if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = PRESC_ZERO;
                        w_time_nxt  = w_dec_time;
                        if (w_dec_zero) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PRESC_ONE;
                    end
                end else begin
                    // Paused: the partial second is kept in r_presc.
                    w_presc_nxt = r_presc;
                end
            end
            DONE: begin
                w_time_nxt  = TIME_ZERO;
                w_state_nxt = IDLE;
            end
            default: begin
                w_time_nxt  = TIME_ZERO;
                w_presc_nxt = PRESC_ZERO;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // One-hot bits double as the Moore outputs.
    assign start   = r_state[1];
    assign running = r_state[2];
    assign finish  = r_state[3];
    assign disp    = r_time;

endmodule

// File: tb/tb_cook_timer.sv
// Randomised scoreboard bench for cook_timer against a seconds/minutes
// arithmetic reference model.
module tb_cook_timer;

    localparam int TPS = 4;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_clear = 1'b0;
    logic        start_btn = 1'b0;
    logic        heat = 1'b0;
    logic        start;
    logic        finish;
    logic        running;
    logic [15:0] disp;

    typedef struct packed {
        logic        start;
        logic        finish;
        logic        running;
        logic [15:0] disp;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode, four entered digits, heat cycles into the current second.
    int m_mode;
    int m_dig[4];
    int m_cyc;

    cook_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .key_clear (key_clear),
        .start_btn (start_btn),
        .heat      (heat),
        .start     (start),
        .finish    (finish),
        .running   (running),
        .disp      (disp)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic bit m_is_zero();
        return (m_dig[0] == 0) && (m_dig[1] == 0) && (m_dig[2] == 0) && (m_dig[3] == 0);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.start   = (m_mode == M_ARM);
        o.running = (m_mode == M_RUN);
        o.finish  = (m_mode == M_DONE);
        o.disp    = 16'(m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3]);
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cyc  = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    // One second less, computed on minutes and seconds as plain integers.
    task automatic model_dec();
        int mm;
        int ss;
        mm = 10 * m_dig[0] + m_dig[1];
        ss = 10 * m_dig[2] + m_dig[3];
        if (ss == 0) begin
            mm = mm - 1;
            ss = 59;
        end else begin
            ss = ss - 1;
        end
        m_dig[0] = mm / 10;
        m_dig[1] = mm % 10;
        m_dig[2] = ss / 10;
        m_dig[3] = ss % 10;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kd, input logic kc,
                              input logic sb, input logic ht);
        case (m_mode)
            M_IDLE: begin
                if (kc) begin
                    for (int i = 0; i < 4; i++) m_dig[i] = 0;
                end else if (kv) begin
                    if (int'(kd) <= 9) begin
                        m_dig[0] = m_dig[1];
                        m_dig[1] = m_dig[2];
                        m_dig[2] = m_dig[3];
                        m_dig[3] = int'(kd);
                    end
                end else if (sb && !m_is_zero()) begin
                    m_mode = M_ARM;
                end
            end
            M_ARM: begin
                m_cyc  = 0;
                m_mode = M_RUN;
            end
            M_RUN: begin
                if (kc) begin
                    for (int i = 0; i < 4; i++) m_dig[i] = 0;
                    m_mode = M_DONE;
                end else if (ht) begin
                    m_cyc = m_cyc + 1;
                    if (m_cyc == TPS) begin
                        m_cyc = 0;
                        model_dec();
                        if (m_is_zero()) m_mode = M_DONE;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input logic kv, input logic [3:0] kd, input logic kc,
                        input logic sb, input logic ht);
        key_valid = kv;
        key_digit = kd;
        key_clear = kc;
        start_btn = sb;
        heat      = ht;
        model_step(kv, kd, kc, sb, ht);
        @(posedge clk);
        exp_q.push_back(model_obs());
        #2;
    endtask

    task automatic cyc(input logic ht, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, ht);
    endtask

    task automatic key(input int d);
        step(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        key(a);
        key(b);
        key(c);
        key(d);
    endtask

    task automatic press_start();
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Assert reset between clock edges; outputs must clear without a clock.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("reset_start",   {31'd0, start},   32'd0);
        chk("reset_finish",  {31'd0, finish},  32'd0);
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_disp",    {16'd0, disp},    32'd0);
        model_reset();
        #1;
        nrst = 1'b1;
    endtask

    // Monitor: pop the expected outputs for every completed cycle and compare.
    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (nrst && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            a = {start, finish, running, disp};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_obs t=%0t got start=%b finish=%b running=%b disp=%h expected start=%b finish=%b running=%b disp=%h",
                         $time, a.start, a.finish, a.running, a.disp,
                         e.start, e.finish, e.running, e.disp);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("por_start",   {31'd0, start},   32'd0);
        chk("por_finish",  {31'd0, finish},  32'd0);
        chk("por_running", {31'd0, running}, 32'd0);
        chk("por_disp",    {16'd0, disp},    32'd0);
        #9;
        nrst = 1'b1;

        // Basic three-second cook.
        load(0, 0, 0, 3);
        press_start();
        cyc(1'b1, 18);

        // Minute borrow, ten-minute borrow, seconds above 59.
        load(0, 1, 0, 0);
        press_start();
        cyc(1'b1, 1 + TPS);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 2);
        load(1, 0, 0, 0);
        press_start();
        cyc(1'b1, 1 + TPS);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        load(0, 1, 9, 9);
        press_start();
        cyc(1'b1, 1 + 2 * TPS);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2);

        // Pause with a partial second held.
        load(0, 0, 0, 2);
        press_start();
        cyc(1'b1, 1);
        cyc(1'b1, 2);
        cyc(1'b0, 20);
        cyc(1'b1, 12);

        // Guards: start at zero, illegal digit, keys during RUN, key with start.
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        press_start();
        cyc(1'b0, 3);
        key(4);
        step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        load(0, 0, 0, 2);
        press_start();
        step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 10);

        // Cancel on the same cycle as a tick, then a normal cook.
        load(0, 0, 0, 2);
        press_start();
        cyc(1'b1, 1 + TPS - 1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 3);
        load(0, 0, 0, 1);
        press_start();
        cyc(1'b1, 10);

        // Reset in the middle of a run, then keypad entry.
        load(0, 0, 0, 5);
        press_start();
        cyc(1'b1, 6);
        mid_reset();
        key(3);
        key(1);
        press_start();
        cyc(1'b1, 3);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            logic kv;
            logic kc;
            logic sb;
            logic ht;
            logic [3:0] kd;
            kv = ($urandom_range(0, 99) < 15);
            kd = 4'($urandom_range(0, 15));
            kc = ($urandom_range(0, 99) < 2);
            sb = ($urandom_range(0, 99) < 10);
            ht = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 999) == 0) begin
                mid_reset();
            end else begin
                step(kv, kd, kc, sb, ht);
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
Countdown timer and keypad front end for the microwave oven controller. It takes a cooking time as MM:SS BCD digits, issues the one-cycle `start` pulse the controller consumes, and counts down only while the controller drives `heat`. When the time expires or is cancelled, it issues the one-cycle `finish` pulse. It sits between the keypad/display and the oven control FSM, closing the start/heat/finish loop.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per countdown second; minimum 2. Bench uses 4.

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe, key_digit valid
key_digit  input  4  keypad digit, 0-9 legal
key_clear  input  1  one-cycle clear/cancel strobe
start_btn  input  1  one-cycle start request
heat  input  1  heater-on from oven controller; counting enable
start  output  1  one-cycle start pulse to oven controller
finish  output  1  one-cycle cooking-finished pulse to oven controller
running  output  1  high while countdown is active (paused or not)
disp  output  16  remaining time, BCD {M1,M0,S1,S0}

Behaviour:
- Clock is clk; reset is nrst, asynchronous, active-low.
- Reset (async, any state, mid-run included): state IDLE, time 0x0000, prescaler 0, start=0, finish=0, running=0, disp=0x0000. Outputs drop immediately on reset, without waiting for a clock edge.
- FSM, one-hot, four states: IDLE, ARM, RUN, DONE. All outputs are Moore outputs:
  - start = ARM
  - running = RUN
  - finish = DONE
  - disp = time register
- IDLE:
  - key_clear -> time 0x0000. It has priority over key_valid in the same cycle.
  - key_valid with digit <= 9 -> time <= {time[11:0], digit}, a BCD shift-left. The oldest digit is lost.
  - key_valid with digit > 9 -> ignored.
  - start_btn with time != 0 -> ARM. start_btn with time == 0 -> ignored, stay IDLE.
  - key_clear or key_valid in the same cycle as start_btn: key handling applies; start_btn is ignored that cycle.
- ARM: lasts exactly one cycle, then RUN unconditionally. Prescaler is cleared to 0. All key inputs and start_btn are ignored.
- RUN:
  - heat=1 -> prescaler increments. When prescaler == TICKS_PER_SEC-1: prescaler <= 0 and time <= dec(time).
  - If dec(time) == 0x0000 -> DONE.
  - heat=0 -> prescaler and time hold. This is pause; a partial second is preserved across the pause.
  - key_clear -> time 0x0000, DONE. This is a cancel, so the controller still receives finish. key_clear has priority over a simultaneous tick.
  - key_valid and start_btn are ignored.
- DONE: lasts exactly one cycle (finish=1), then IDLE. Time stays 0x0000.
- dec(MM:SS):
  - If SS == 00: MM <= MM-1 (BCD), SS <= 59.
  - Otherwise SS <= SS-1 (BCD, borrow from S1 when S0 == 0).
  - Seconds entries above 59 are legal and count down as entered, e.g. 01:99 -> 01:98 ... 01:00 -> 00:59.
  - dec is never applied to 0000.
- Latency:
  - start is high in the cycle after start_btn is sampled.
  - finish is high in the cycle after the clock edge that makes time 0000.
  - From start_btn to finish: 1 + 1 + N*TICKS_PER_SEC heat-high cycles, for a load of N seconds.
- If heat never rises (e.g. door open), the block stays in RUN indefinitely. key_clear or reset is the only exit.
- Prescaler width is $clog2(TICKS_PER_SEC). The prescaler never exceeds TICKS_PER_SEC-1.

Decomposition:
- Package mw_pkg holds:
  - one-hot state constants IDLE=4'b0001, ARM=4'b0010, RUN=4'b0100, DONE=4'b1000
  - typedef bcd_t (logic [3:0])
  - typedef mmss_t (logic [15:0])
  - constant TIME_ZERO
- One sub-module, mw_time_dec: combinational MM:SS BCD decrement, mmss_t in -> mmss_t out plus is_zero flag. It is unit-testable on its own.
- FSM, prescaler, and keypad shift register live in cook_timer.

Test Plan:
1. TICKS_PER_SEC=4. Keys 0,0,0,3 -> disp=0x0003. Pulse start_btn -> start=1 for exactly 1 cycle, then running=1. Hold heat=1 -> disp steps 0002, 0001, 0000 at 4-cycle spacing. finish=1 for 1 cycle after the 12th RUN cycle, then running=0 and IDLE.
2. Borrow: load 0100 and run one second -> disp=0x0059. Separately, load 1000 -> after 1 s disp=0x0959.
3. Pause: load 0002, run 2 heat cycles, drop heat for 20 cycles -> disp=0x0002 and no tick. Restore heat -> first tick after exactly 2 more cycles.
4. Guards:
   - start_btn with disp=0000 -> start never rises, state stays IDLE.
   - key_digit=0xA with key_valid -> disp unchanged.
   - key_valid during RUN -> disp unchanged.
5. Cancel: key_clear during RUN, coinciding with a tick -> disp=0x0000, finish=1 for 1 cycle, then IDLE. A subsequent load and start works normally.
6. Reset: nrst low mid-RUN between clock edges -> start, finish, running and disp are 0 immediately. After nrst rises -> IDLE, and keypad entry works.
